// File: rtl/data_mem_stage_pkg.sv
// data_mem_stage_pkg
//   Shared definitions for the MEM stage: RV32I funct3 width codes, FSM state
//   encoding, and the lane helpers used for little-endian byte/half/word access.
//   No ports (package).
package data_mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } st_lanes_t;

    // Unsigned widths only exist for loads; any code outside the RV32I set is
    // treated as a misaligned access so it never writes memory.
    function automatic logic access_misaligned(input logic       is_store,
                                               input logic [2:0] f3,
                                               input logic [1:0] lo);
        logic bad;
        bad = 1'b1;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = is_store;
            F3_H:    bad = lo[0];
            F3_HU:   bad = is_store | lo[0];
            F3_W:    bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lo);
        logic [31:0] sh;
        logic [31:0] res;
        sh  = word >> {lo, 3'b000};
        res = '0;
        case (f3)
            F3_B:    res = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   res = {24'h0, sh[7:0]};
            F3_H:    res = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   res = {16'h0, sh[15:0]};
            F3_W:    res = word;
            default: res = '0;
        endcase
        return res;
    endfunction

    // Store data is replicated across lanes so the byte enables alone pick
    // the destination bytes.
    function automatic st_lanes_t store_lanes(input logic [2:0]  f3,
                                              input logic [1:0]  lo,
                                              input logic [31:0] wdata);
        st_lanes_t r;
        r.be   = 4'b0000;
        r.data = wdata;
        case (f3)
            F3_B: begin
                r.be   = 4'b0001 << lo;
                r.data = {4{wdata[7:0]}};
            end
            F3_H: begin
                r.be   = lo[1] ? 4'b1100 : 4'b0011;
                r.data = {2{wdata[15:0]}};
            end
            F3_W: begin
                r.be   = 4'b1111;
                r.data = wdata;
            end
            default: begin
                r.be   = 4'b0000;
                r.data = wdata;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array
//   DEPTH_WORDS x 32 data RAM with per-byte write enables. Asynchronous read,
//   synchronous write, contents not reset.
// Ports
//   clk    in   clock, writes on posedge
//   idx    in   word index (read and write share it)
//   we     in   byte write enables, bit b writes bits [8b+7:8b]
//   wdata  in   write data (lane aligned)
//   rdata  out  word at idx, combinational
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] idx,
    input  logic [3:0]       we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_stage.sv
// data_mem_stage
//   MEM stage: accepts one load/store, waits MEM_LAT cycles, then performs the
//   access against dmem_array and registers the completion outputs.
// Ports
//   clk, rstn                         clock, async active-low reset
//   req_valid/req_ready               request handshake (ready is combinational)
//   req_is_store, req_funct3          op kind and width/sign
//   req_addr, req_wdata, req_pc, req_tag  request payload
//   flush                             kills an in-flight load, blocks acceptance
//   mem_valid, lw_data_out, pc_out, tag_out  load completion
//   st_done                           store completion pulse
//   misalign_err                      flags a misaligned completion
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no op in flight; accepts a request when req_ready
// ST_BUSY | latched op waiting; cnt counts down to the access edge
module data_mem_stage
    import data_mem_stage_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int MEM_LAT     = 2,
    parameter int TAG_W       = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_is_store,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [31:0]      req_pc,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             mem_valid,
    output logic [31:0]      lw_data_out,
    output logic [31:0]      pc_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             st_done,
    output logic             misalign_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_is_store;
    logic [2:0]         lat_funct3;
    logic [IDX_W+1:0]   lat_addr;
    logic [31:0]        lat_wdata;
    logic [31:0]        lat_pc;
    logic [TAG_W-1:0]   lat_tag;

    logic               accept;
    logic               kill;
    logic               access;
    logic               misal;
    st_lanes_t          lanes;
    logic [3:0]         arr_we;
    logic [31:0]        arr_rdata;
    logic [31:0]        load_val;

    // Upper address bits are deliberately ignored: the array wraps.
    logic               unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:IDX_W+2];

    assign req_ready = (state == ST_IDLE) && !flush;
    assign accept    = req_valid && req_ready;
    // A flush only cancels loads; a committed store always completes.
    assign kill      = (state == ST_BUSY) && flush && !lat_is_store;
    assign access    = (state == ST_BUSY) && (cnt == '0) && !kill;

    assign misal    = access_misaligned(lat_is_store, lat_funct3, lat_addr[1:0]);
    assign lanes    = store_lanes(lat_funct3, lat_addr[1:0], lat_wdata);
    assign arr_we   = (access && lat_is_store && !misal) ? lanes.be : 4'b0000;
    assign load_val = misal ? 32'h0 : load_extend(arr_rdata, lat_funct3, lat_addr[1:0]);

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_dmem (
        .clk  (clk),
        .idx  (lat_addr[IDX_W+1:2]),
        .we   (arr_we),
        .wdata(lanes.data),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            lat_is_store <= 1'b0;
            lat_funct3   <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_pc       <= '0;
            lat_tag      <= '0;
            mem_valid    <= 1'b0;
            lw_data_out  <= '0;
            pc_out       <= '0;
            tag_out      <= '0;
            st_done      <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            mem_valid    <= 1'b0;
            st_done      <= 1'b0;
            misalign_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_is_store <= req_is_store;
                        lat_funct3   <= req_funct3;
                        lat_addr     <= req_addr[IDX_W+1:0];
                        lat_wdata    <= req_wdata;
                        lat_pc       <= req_pc;
                        lat_tag      <= req_tag;
                        cnt          <= CNT_INIT;
                        state        <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (kill) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state        <= ST_IDLE;
                        pc_out       <= lat_pc;
                        misalign_err <= misal;
                        if (lat_is_store) begin
                            st_done <= 1'b1;
                        end else begin
                            mem_valid   <= 1'b1;
                            lw_data_out <= load_val;
                            tag_out     <= lat_tag;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
